// File: rtl/wave_fb_writer.sv
// wave_fb_writer
//   Write-side engine of a ping-pong 1-bit frame buffer. Each accepted sample
//   becomes one display column: the sample is scaled to a screen row, then a
//   full vertical stripe is written into the active bank (1 at the trace row,
//   0 elsewhere). After the last column the bank is held until the scan-out
//   side acknowledges a swap.
//
// Ports
//   clkWR        write-domain clock (rising edge)
//   rst          synchronous active-high reset
//   val          unsigned sample, val_valid / val_ready handshake
//   swap_ack     one-cycle pulse: reader has switched to the finished bank
//   frame_ready  frame complete, waiting for swap_ack
//   wr_bank      bank currently being written (0 = bank0)
//   EN0/WE0/addrB0, EN1/WE1/addrB1, WD   BRAM port A of both banks
//   col_x, row_r current column and computed trace row (debug)
module wave_fb_writer #(
  parameter int ADDR_WIDTH  = 19,
  parameter int VAL_RES     = 16,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int LOG2_WIDTH  = 10,
  parameter int LOG2_HEIGHT = 9
) (
  input  logic                   clkWR,
  input  logic                   rst,
  input  logic [VAL_RES-1:0]     val,
  input  logic                   val_valid,
  output logic                   val_ready,
  input  logic                   swap_ack,
  output logic                   frame_ready,
  output logic                   wr_bank,
  output logic                   EN0,
  output logic                   WE0,
  output logic [ADDR_WIDTH-1:0]  addrB0,
  output logic                   EN1,
  output logic                   WE1,
  output logic [ADDR_WIDTH-1:0]  addrB1,
  output logic                   WD,
  output logic [LOG2_WIDTH-1:0]  col_x,
  output logic [LOG2_HEIGHT-1:0] row_r
);

  localparam int MUL_W = VAL_RES + LOG2_HEIGHT;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_VAL  = 3'd1,
    MUL       = 3'd2,
    ROW       = 3'd3,
    COLUMN    = 3'd4,
    FRAME_END = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [VAL_RES-1:0]     val_q;
  logic [MUL_W-1:0]       val_mul_q;
  logic [LOG2_HEIGHT-1:0] row_r_q;
  logic [LOG2_HEIGHT-1:0] y_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LOG2_WIDTH-1:0]  col_x_q;
  logic                   wr_bank_q;
  logic                   val_ready_q;
  logic                   frame_ready_q;
  logic                   en0_q, en1_q, wd_q;
  logic [ADDR_WIDTH-1:0]  addr0_q, addr1_q;

  logic                   accept_s, swap_s, y_last_s, col_last_s;
  logic                   wr_s, en0_d, en1_d, wd_d;
  logic [ADDR_WIDTH-1:0]  addr0_d, addr1_d;

  // Handshakes are qualified by the registered flags so that a sample or a
  // swap is only taken while the matching output is actually high.
  assign accept_s   = (state_q == WAIT_VAL) && val_ready_q && val_valid;
  assign swap_s     = (state_q == FRAME_END) && frame_ready_q && swap_ack;
  assign y_last_s   = (y_q == LOG2_HEIGHT'(HEIGHT - 1));
  assign col_last_s = (col_x_q == LOG2_WIDTH'(WIDTH - 1));

  // State register.
  always_ff @(posedge clkWR) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = WAIT_VAL;
      WAIT_VAL: begin
        if (accept_s) state_d = MUL;
        else          state_d = WAIT_VAL;
      end
      MUL:      state_d = ROW;
      ROW:      state_d = COLUMN;
      COLUMN: begin
        if (y_last_s) begin
          if (col_last_s) state_d = FRAME_END;
          else            state_d = WAIT_VAL;
        end else begin
          state_d = COLUMN;
        end
      end
      FRAME_END: begin
        if (swap_s) state_d = WAIT_VAL;
        else        state_d = FRAME_END;
      end
      default:  state_d = IDLE;
    endcase
  end

  // BRAM port values for the current COLUMN cycle; the unselected bank idles at 0.
  always_comb begin
    wr_s  = (state_q == COLUMN);
    en0_d = wr_s && !wr_bank_q;
    en1_d = wr_s && wr_bank_q;
    wd_d  = wr_s && (y_q == row_r_q);
    if (en0_d) addr0_d = addr_q;
    else       addr0_d = {ADDR_WIDTH{1'b0}};
    if (en1_d) addr1_d = addr_q;
    else       addr1_d = {ADDR_WIDTH{1'b0}};
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge clkWR) begin
    if (rst) begin
      val_q         <= {VAL_RES{1'b0}};
      val_mul_q     <= {MUL_W{1'b0}};
      row_r_q       <= {LOG2_HEIGHT{1'b0}};
      y_q           <= {LOG2_HEIGHT{1'b0}};
      addr_q        <= {ADDR_WIDTH{1'b0}};
      col_x_q       <= {LOG2_WIDTH{1'b0}};
      wr_bank_q     <= 1'b0;
      val_ready_q   <= 1'b0;
      frame_ready_q <= 1'b0;
      en0_q         <= 1'b0;
      en1_q         <= 1'b0;
      wd_q          <= 1'b0;
      addr0_q       <= {ADDR_WIDTH{1'b0}};
      addr1_q       <= {ADDR_WIDTH{1'b0}};
    end else begin
      // The first WAIT_VAL cycle after IDLE keeps val_ready low, so the block
      // offers its first slot on the second edge out of reset.
      val_ready_q   <= (state_d == WAIT_VAL) && (state_q != IDLE);
      // frame_ready follows the last write by one cycle and drops on the swap.
      frame_ready_q <= (state_q == FRAME_END) && (state_d == FRAME_END);
      en0_q         <= en0_d;
      en1_q         <= en1_d;
      wd_q          <= wd_d;
      addr0_q       <= addr0_d;
      addr1_q       <= addr1_d;
      if (accept_s) begin
        val_q <= val;
      end
      case (state_q)
        IDLE: begin
          col_x_q <= {LOG2_WIDTH{1'b0}};
        end
        MUL: begin
          // Full-width product, nothing truncated.
          val_mul_q <= MUL_W'(val_q) * MUL_W'(HEIGHT);
        end
        ROW: begin
          // Integer part of val*HEIGHT/2^VAL_RES, flipped so val=0 is the bottom row.
          row_r_q <= LOG2_HEIGHT'(HEIGHT - 1) - LOG2_HEIGHT'(val_mul_q >> VAL_RES);
          y_q     <= {LOG2_HEIGHT{1'b0}};
          addr_q  <= ADDR_WIDTH'(col_x_q);
        end
        COLUMN: begin
          // Row stride is added each cycle instead of multiplying y*WIDTH.
          y_q    <= y_q + LOG2_HEIGHT'(1);
          addr_q <= addr_q + ADDR_WIDTH'(WIDTH);
          if (y_last_s && !col_last_s) begin
            col_x_q <= col_x_q + LOG2_WIDTH'(1);
          end
        end
        FRAME_END: begin
          if (swap_s) begin
            wr_bank_q <= ~wr_bank_q;
            col_x_q   <= {LOG2_WIDTH{1'b0}};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign val_ready   = val_ready_q;
  assign frame_ready = frame_ready_q;
  assign wr_bank     = wr_bank_q;
  assign EN0         = en0_q;
  assign WE0         = en0_q;
  assign addrB0      = addr0_q;
  assign EN1         = en1_q;
  assign WE1         = en1_q;
  assign addrB1      = addr1_q;
  assign WD          = wd_q;
  assign col_x       = col_x_q;
  assign row_r       = row_r_q;

endmodule

// File: tb/tb_wave_fb_writer.sv
// Self-checking bench for wave_fb_writer with an 8x6 screen.
// Expected BRAM writes are queued when a sample is offered and compared in
// order against the writes captured from the pins.
module tb_wave_fb_writer;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int AW = 6;
  localparam int LW = 3;
  localparam int LH = 3;
  localparam int VR = 16;

  logic          clkWR = 1'b0;
  logic          rst = 1'b1;
  logic [VR-1:0] val = 16'h0000;
  logic          val_valid = 1'b0;
  logic          val_ready;
  logic          swap_ack = 1'b0;
  logic          frame_ready;
  logic          wr_bank;
  logic          EN0, WE0, EN1, WE1, WD;
  logic [AW-1:0] addrB0, addrB1;
  logic [LW-1:0] col_x;
  logic [LH-1:0] row_r;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int writes_seen = 0;
  int last_write_cyc = 0;
  int obs_rd = 0;
  int exp_col = 0;
  bit exp_bank = 1'b0;
  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];

  wave_fb_writer #(
    .ADDR_WIDTH (AW),
    .VAL_RES    (VR),
    .WIDTH      (W),
    .HEIGHT     (H),
    .LOG2_WIDTH (LW),
    .LOG2_HEIGHT(LH)
  ) dut (
    .clkWR      (clkWR),
    .rst        (rst),
    .val        (val),
    .val_valid  (val_valid),
    .val_ready  (val_ready),
    .swap_ack   (swap_ack),
    .frame_ready(frame_ready),
    .wr_bank    (wr_bank),
    .EN0        (EN0),
    .WE0        (WE0),
    .addrB0     (addrB0),
    .EN1        (EN1),
    .WE1        (WE1),
    .addrB1     (addrB1),
    .WD         (WD),
    .col_x      (col_x),
    .row_r      (row_r)
  );

  always #5 clkWR = ~clkWR;

  always @(posedge clkWR) cyc <= cyc + 1;

  // Capture every BRAM access on the falling edge.
  always @(negedge clkWR) begin
    if (EN0 || WE0 || EN1 || WE1) begin
      obs_q.push_back({EN0, WE0, addrB0, EN1, WE1, addrB1, WD});
      writes_seen    <= writes_seen + 1;
      last_write_cyc <= cyc;
    end
  end

  task automatic tick();
    @(posedge clkWR);
    @(negedge clkWR);
    #1;
  endtask

  function automatic logic [16:0] mk_entry(input bit bank, input int addr, input bit wd);
    logic [5:0] a;
    a = 6'(addr);
    if (bank) return {1'b0, 1'b0, 6'd0, 1'b1, 1'b1, a, wd};
    else      return {1'b1, 1'b1, a, 1'b0, 1'b0, 6'd0, wd};
  endfunction

  // Offer one sample, queue the stripe it should produce, return after the accept edge.
  task automatic drive_column(input logic [15:0] v, input int nexp, input bit hold, output int acc_cyc);
    int n;
    int r;
    val = v;
    val_valid = 1'b1;
    n = 0;
    while (val_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: val_ready observed %b, required 1 within 50 cycles", val_ready);
    end
    r = (H - 1) - ((int'(v) * H) >> 16);
    for (int y = 0; y < nexp; y++) exp_q.push_back(mk_entry(exp_bank, y * W + exp_col, (y == r)));
    tick();
    acc_cyc = cyc;
    if (!hold) val_valid = 1'b0;
    exp_col = (exp_col + 1) % W;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({val_ready, frame_ready, wr_bank, EN0, WE0, EN1, WE1, WD} !== 8'b0 ||
        addrB0 !== 6'd0 || addrB1 !== 6'd0 || col_x !== 3'd0 || row_r !== 3'd0) begin
      bad++;
      $display("FAIL reset_values: observed rdy=%b fr=%b bank=%b en=%b%b%b%b wd=%b a0=%0d a1=%0d col=%0d row=%0d, required all 0",
               val_ready, frame_ready, wr_bank, EN0, WE0, EN1, WE1, WD, addrB0, addrB1, col_x, row_r);
    end
    rst = 1'b0;
    tick();
    total++;
    if (val_ready !== 1'b0) begin bad++; $display("FAIL ready_edge1: observed %b required 0", val_ready); end
    tick();
    total++;
    if (val_ready !== 1'b1) begin bad++; $display("FAIL ready_edge2: observed %b required 1", val_ready); end
  endtask

  task automatic test_first_column();
    int acc, n;
    logic [16:0] e;
    drive_column(16'h8000, H, 1'b0, acc);
    total++;
    if (writes_seen !== 0) begin bad++; $display("FAIL lat_e0: observed %0d writes required 0", writes_seen); end
    tick();
    tick();
    total++;
    if (writes_seen !== 0) begin bad++; $display("FAIL lat_e2: observed %0d writes required 0", writes_seen); end
    tick();
    total++;
    if ({EN0, WE0, EN1, WE1} !== 4'b1100 || addrB0 !== 6'd0) begin
      bad++;
      $display("FAIL lat_e3: observed en=%b%b%b%b a0=%0d required 1100 a0=0", EN0, WE0, EN1, WE1, addrB0);
    end
    n = 0;
    while (obs_q.size() - obs_rd < exp_q.size() && n < 200) begin tick(); n++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_rd >= obs_q.size()) begin bad++; $display("FAIL col0_write: observed none required %h", e); end
      else begin
        if (obs_q[obs_rd] !== e) begin bad++; $display("FAIL col0_write[%0d]: observed %h required %h", obs_rd, obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    total++;
    if (obs_q.size() != obs_rd) begin bad++; $display("FAIL col0_extra: observed %0d extra writes required 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
    total++;
    if (row_r !== 3'd2 || col_x !== 3'd1) begin bad++; $display("FAIL col0_row: observed row=%0d col=%0d required row=2 col=1", row_r, col_x); end
  endtask

  task automatic test_extremes();
    int acc, n;
    logic [16:0] e;
    logic [15:0] vals[2];
    logic [2:0]  rows[2];
    vals[0] = 16'hFFFF; rows[0] = 3'd0;
    vals[1] = 16'h0000; rows[1] = 3'd5;
    for (int k = 0; k < 2; k++) begin
      drive_column(vals[k], H, 1'b0, acc);
      n = 0;
      while (obs_q.size() - obs_rd < exp_q.size() && n < 200) begin tick(); n++; end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (obs_rd >= obs_q.size()) begin bad++; $display("FAIL extreme_write: observed none required %h", e); end
        else begin
          if (obs_q[obs_rd] !== e) begin bad++; $display("FAIL extreme_write[%0d]: observed %h required %h", obs_rd, obs_q[obs_rd], e); end
          obs_rd++;
        end
      end
      total++;
      if (obs_q.size() != obs_rd) begin bad++; $display("FAIL extreme_extra: observed %0d extra required 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
      total++;
      if (row_r !== rows[k]) begin bad++; $display("FAIL extreme_row: val=%h observed %0d required %0d", vals[k], row_r, rows[k]); end
    end
  endtask

  task automatic test_gap();
    int acc, n, w0;
    logic [16:0] e;
    w0 = writes_seen;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (val_ready !== 1'b1 || col_x !== 3'd3) begin bad++; $display("FAIL gap_idle: observed rdy=%b col=%0d required rdy=1 col=3", val_ready, col_x); end
      tick();
    end
    total++;
    if (writes_seen !== w0) begin bad++; $display("FAIL gap_writes: observed %0d writes required %0d", writes_seen, w0); end
    drive_column(16'($urandom_range(0, 65535)), H, 1'b0, acc);
    n = 0;
    while (obs_q.size() - obs_rd < exp_q.size() && n < 200) begin tick(); n++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_rd >= obs_q.size()) begin bad++; $display("FAIL gap_write: observed none required %h", e); end
      else begin
        if (obs_q[obs_rd] !== e) begin bad++; $display("FAIL gap_write[%0d]: observed %h required %h", obs_rd, obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    total++;
    if (obs_q.size() != obs_rd) begin bad++; $display("FAIL gap_extra: observed %0d extra required 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
  endtask

  task automatic test_back_to_back();
    int acc[4];
    int n, w0;
    logic [16:0] e;
    for (int k = 0; k < 4; k++) drive_column(16'($urandom_range(0, 65535)), H, 1'b1, acc[k]);
    for (int k = 1; k < 4; k++) begin
      total++;
      if (acc[k] - acc[k-1] !== H + 3) begin bad++; $display("FAIL col_period: observed %0d cycles required %0d", acc[k] - acc[k-1], H + 3); end
    end
    n = 0;
    while (frame_ready !== 1'b1 && n < 100) begin tick(); n++; end
    total++;
    if (frame_ready !== 1'b1 || cyc !== last_write_cyc + 1) begin
      bad++;
      $display("FAIL frame_ready_rise: observed fr=%b at cycle %0d required 1 at cycle %0d", frame_ready, cyc, last_write_cyc + 1);
    end
    total++;
    if (writes_seen !== W * H) begin bad++; $display("FAIL frame_writes: observed %0d required %0d", writes_seen, W * H); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_rd >= obs_q.size()) begin bad++; $display("FAIL b2b_write: observed none required %h", e); end
      else begin
        if (obs_q[obs_rd] !== e) begin bad++; $display("FAIL b2b_write[%0d]: observed %h required %h", obs_rd, obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    w0 = writes_seen;
    for (int k = 0; k < 20; k++) begin
      tick();
      total++;
      if (val_ready !== 1'b0 || frame_ready !== 1'b1) begin bad++; $display("FAIL frame_hold: observed rdy=%b fr=%b required rdy=0 fr=1", val_ready, frame_ready); end
    end
    total++;
    if (writes_seen !== w0) begin bad++; $display("FAIL frame_hold_writes: observed %0d required %0d", writes_seen, w0); end
  endtask

  task automatic test_swap();
    int acc, n, w0;
    logic [16:0] e;
    w0 = writes_seen;
    val = 16'h4000;
    swap_ack = 1'b1;
    tick();
    swap_ack = 1'b0;
    total++;
    if (wr_bank !== 1'b1 || frame_ready !== 1'b0 || val_ready !== 1'b1 || col_x !== 3'd0 || writes_seen !== w0) begin
      bad++;
      $display("FAIL swap_taken: observed bank=%b fr=%b rdy=%b col=%0d writes=%0d required 1 0 1 0 %0d",
               wr_bank, frame_ready, val_ready, col_x, writes_seen, w0);
    end
    exp_bank = 1'b1;
    drive_column(16'h4000, H, 1'b0, acc);
    repeat (3) tick();
    swap_ack = 1'b1;
    tick();
    swap_ack = 1'b0;
    total++;
    if (wr_bank !== 1'b1) begin bad++; $display("FAIL swap_ignored: observed bank=%b required 1", wr_bank); end
    n = 0;
    while (obs_q.size() - obs_rd < exp_q.size() && n < 200) begin tick(); n++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_rd >= obs_q.size()) begin bad++; $display("FAIL bank1_write: observed none required %h", e); end
      else begin
        if (obs_q[obs_rd] !== e) begin bad++; $display("FAIL bank1_write[%0d]: observed %h required %h", obs_rd, obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    total++;
    if (obs_q.size() != obs_rd) begin bad++; $display("FAIL bank1_extra: observed %0d extra required 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
  endtask

  task automatic test_reset_mid();
    int acc, n;
    logic [16:0] e;
    for (int k = 1; k < 4; k++) drive_column(16'($urandom_range(0, 65535)), H, 1'b1, acc);
    drive_column(16'h2345, 4, 1'b0, acc);
    n = 0;
    while (!(EN1 === 1'b1 && addrB1 === 6'(3 * W + 4)) && n < 100) begin tick(); n++; end
    total++;
    if (n >= 100) begin bad++; $display("FAIL mid_wait: observed no write at addr %0d, required one", 3 * W + 4); end
    rst = 1'b1;
    tick();
    total++;
    if ({EN0, WE0, EN1, WE1, WD, wr_bank, val_ready, frame_ready} !== 8'b0 || col_x !== 3'd0 ||
        addrB0 !== 6'd0 || addrB1 !== 6'd0) begin
      bad++;
      $display("FAIL mid_reset: observed en=%b%b%b%b wd=%b bank=%b rdy=%b fr=%b col=%0d required all 0",
               EN0, WE0, EN1, WE1, WD, wr_bank, val_ready, frame_ready, col_x);
    end
    rst = 1'b0;
    tick();
    total++;
    if (val_ready !== 1'b0) begin bad++; $display("FAIL mid_ready1: observed %b required 0", val_ready); end
    tick();
    total++;
    if (val_ready !== 1'b1) begin bad++; $display("FAIL mid_ready2: observed %b required 1", val_ready); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_rd >= obs_q.size()) begin bad++; $display("FAIL mid_write: observed none required %h", e); end
      else begin
        if (obs_q[obs_rd] !== e) begin bad++; $display("FAIL mid_write[%0d]: observed %h required %h", obs_rd, obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    total++;
    if (obs_q.size() != obs_rd) begin bad++; $display("FAIL mid_extra: observed %0d extra required 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
  endtask

  initial begin
    test_reset();
    test_first_column();
    test_extremes();
    test_gap();
    test_back_to_back();
    test_swap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_fb_writer.md
# wave_fb_writer

Write-side engine of the oscilloscope's ping-pong 1-bit frame buffer. It accepts one sample per display column on the clkWR domain and scales it to a screen row. For that column it writes a full vertical stripe into the active bank: 1 at the trace row, 0 everywhere else. After the last column it holds the bank until the scan-out side acknowledges a swap. Outputs connect directly to port A (EN/WE/addr/din) of the two single-bit BRAM banks read by the HDMI scan-out.

## Interface
- ADDR_WIDTH, 19, BRAM address width; must satisfy WIDTH*HEIGHT <= 2^ADDR_WIDTH
- VAL_RES, 16, sample width in bits
- WIDTH, 640, active columns
- HEIGHT, 480, active rows
- LOG2_WIDTH, 10, width of column counter
- LOG2_HEIGHT, 9, width of row counter
---
- clkWR  in  1  write-domain clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- val  in  VAL_RES  unsigned sample
- val_valid  in  1  sample present
- val_ready  out  1  block accepts sample this cycle
- swap_ack  in  1  single-cycle pulse, already synchronised to clkWR; reader has switched to the finished bank
- frame_ready  out  1  frame complete, waiting for swap
- wr_bank  out  1  bank currently written (0 = bank0)
- EN0, WE0  out  1  bank0 enable / write enable
- addrB0  out  ADDR_WIDTH  bank0 address
- EN1, WE1  out  1  bank1 enable / write enable
- addrB1  out  ADDR_WIDTH  bank1 address
- WD  out  1  write data, shared by both banks
- col_x  out  LOG2_WIDTH  current column (debug)
- row_r  out  LOG2_HEIGHT  computed trace row (debug)

## Operation
- States: IDLE, WAIT_VAL, MUL, ROW, COLUMN, FRAME_END.
- IDLE: one cycle, then WAIT_VAL with col_x=0.
- WAIT_VAL: val_ready=1. When val_valid is high, capture val and go to MUL. val_valid in any other state is ignored.
- MUL: valMul = val*HEIGHT, VAL_RES+LOG2_HEIGHT bits, no truncation. Go to ROW.
- ROW: row_r = HEIGHT-1 - (valMul >> VAL_RES). Range is 0..HEIGHT-1; val=0 gives the bottom row, full scale gives row 0. Load y=0 and addr=col_x. Go to COLUMN.
- COLUMN: one write per cycle for y = 0..HEIGHT-1.
  - Selected bank: EN=WE=1, addr = y*WIDTH + col_x, formed by adding WIDTH each cycle (no multiplier). WD = (y == row_r).
  - On y = HEIGHT-1: if col_x = WIDTH-1, go to FRAME_END; otherwise increment col_x and return to WAIT_VAL.
- FRAME_END: frame_ready=1, no writes. On swap_ack, toggle wr_bank, clear frame_ready, set col_x=0, go to WAIT_VAL. swap_ack in any other state is ignored.
- Bank not selected by wr_bank: EN=WE=0 and addr=0 at all times.
- All outputs are registered.

## Timing
- Reset values: state IDLE, val_ready=0, frame_ready=0, wr_bank=0, all EN/WE=0, addresses 0, WD=0, col_x=0, row_r=0.
- First val_ready=1 is the 2nd rising edge after rst deasserts.
- Handshake edge to first write on BRAM pins: 3 cycles (MUL, ROW, then first COLUMN cycle registered).
- Column period with continuous val_valid: HEIGHT+3 cycles (WAIT_VAL + MUL + ROW + HEIGHT writes).
- Frame time: WIDTH*(HEIGHT+3) cycles plus swap wait.
- frame_ready rises the cycle after the last write.
- swap_ack sampled while frame_ready=1: wr_bank toggles and val_ready=1 on the next edge.
- rst mid-column or mid-FRAME_END: next edge applies all reset values; the partial column is abandoned and the reader does not see the bank switch.
- val_valid and swap_ack both high in FRAME_END: only the swap is taken; the sample is not consumed.

## Test plan
Parameters for all scenarios: WIDTH=8, HEIGHT=6, LOG2_WIDTH=3, LOG2_HEIGHT=3, ADDR_WIDTH=6.
- Reset then val=0x8000 with val_valid held -> valMul=0x30000, row_r=2; bank0 writes addr 0,8,16,24,32,40 with WD=1 only at 16; EN1/WE1 stay 0.
- Extremes: val=0xFFFF -> row_r=0, WD=1 at addr col_x. val=0x0000 -> row_r=5, WD=1 at 40+col_x.
- Eight columns with val_valid held -> 48 write cycles total, frame_ready=1 after column 7; holding val_valid for 20 more cycles causes no writes and val_ready stays 0.
- swap_ack pulse in FRAME_END -> wr_bank=1, frame_ready=0; next column writes only bank1 starting at addr 0. A swap_ack pulse during COLUMN is ignored.
- val_valid dropped for 5 cycles between columns -> val_ready stays 1, no writes, col_x unchanged; resumes correctly when val_valid returns.
- rst asserted at y=3 of column 4 in bank1 -> next edge: all EN/WE=0, wr_bank=0, col_x=0; val_ready=1 two edges after release.
